// File: rtl/pwm9_stage_if.sv
// rtl/pwm9_stage_if.sv - valid/ready sample channel into the pwm9_stage output stage
`timescale 1ns/1ps
interface pwm9_stage_if;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_code;
  logic [3:0] in_frac;

  modport master (
    output in_valid,
    output in_code,
    output in_frac,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_code,
    input  in_frac,
    output in_ready
  );
endinterface

// File: rtl/pwm9_stage.sv
// rtl/pwm9_stage.sv - 512-tick PWM stage with period-synchronous duty update (FRACTION_EN adds 4-bit fraction)
`timescale 1ns/1ps
module pwm9_stage #(
  parameter int PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  pwm9_stage_if.slave in_if,
  output logic        pwm_out,
  output logic        period_start,
  output logic        underrun,
  output logic [8:0]  duty_q
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  localparam logic [7:0] PRESC_LAST = 8'(PRESCALE - 1);

  state_e     state_q, state_d;
  logic [8:0] phase_q, phase_d;
  logic [7:0] presc_q, presc_d;
  logic       full_q, full_d;
  logic [8:0] pend_q, pend_d;
  logic       in_ready_q, in_ready_d;
  logic [8:0] duty_d;
  logic       pwm_out_q, pwm_out_d;
  logic       period_start_q, period_start_d;
  logic       underrun_q, underrun_d;

  logic [8:0] in_word;
  logic       xfer;
  logic       boundary;

`ifdef FRACTION_EN
  assign in_word = {in_if.in_code, in_if.in_frac};
`else
  // Coarse mode: the fraction is dropped, duty moves in steps of 16 ticks.
  logic unused_frac;
  assign unused_frac = ^in_if.in_frac;
  assign in_word = {in_if.in_code, 4'b0000};
`endif

  assign xfer = in_if.in_valid && in_ready_q;

  // A boundary only exists while actually running; the cycle that leaves RUN
  // because enable fell is not treated as a period start.
  assign boundary = (state_q == RUN) && enable && (phase_q == 9'd0) && (presc_q == 8'd0);

  // Next-state: run/idle control, tick/phase counting, pending buffer and duty latch.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    presc_d        = presc_q;
    full_d         = full_q;
    pend_d         = pend_q;
    duty_d         = duty_q;
    pwm_out_d      = 1'b0;
    period_start_d = boundary;
    underrun_d     = boundary && !full_q;

    // The buffer is consumed at a boundary; it cannot be refilled in the same
    // cycle because in_ready is still low while it is full.
    if (boundary && full_q) begin
      duty_d = pend_q;
      full_d = 1'b0;
    end
    if (xfer) begin
      pend_d = in_word;
      full_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        phase_d = 9'd0;
        presc_d = 8'd0;
        if (enable) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          phase_d = 9'd0;
          presc_d = 8'd0;
        end else begin
          if (presc_q == PRESC_LAST) begin
            presc_d = 8'd0;
            phase_d = phase_q + 9'd1;
          end else begin
            presc_d = presc_q + 8'd1;
          end
          // Compare against the duty taking effect now so phase 0 of a new
          // period already uses the freshly loaded value.
          pwm_out_d = (phase_q < duty_d);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = !full_d;
  end

  // State register; reset discards any pending sample and the active duty.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      phase_q        <= 9'd0;
      presc_q        <= 8'd0;
      full_q         <= 1'b0;
      pend_q         <= 9'd0;
      in_ready_q     <= 1'b1;
      duty_q         <= 9'd0;
      pwm_out_q      <= 1'b0;
      period_start_q <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      presc_q        <= presc_d;
      full_q         <= full_d;
      pend_q         <= pend_d;
      in_ready_q     <= in_ready_d;
      duty_q         <= duty_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
      underrun_q     <= underrun_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign pwm_out        = pwm_out_q;
  assign period_start   = period_start_q;
  assign underrun       = underrun_q;

endmodule

// File: tb/tb_pwm9_stage.sv
// tb/tb_pwm9_stage.sv - self-checking bench for pwm9_stage (honours FRACTION_EN)
`timescale 1ns/1ps
module tb_pwm9_stage;

  localparam int PER0 = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       enable0, enable1;
  logic       pwm0, ps0, ur0;
  logic [8:0] duty0;
  logic       pwm1, ps1, ur1;
  logic [8:0] duty1;

  pwm9_stage_if if0();
  pwm9_stage_if if1();

  pwm9_stage #(.PRESCALE(1)) u0 (
    .clk(clk), .reset(reset), .enable(enable0), .in_if(if0.slave),
    .pwm_out(pwm0), .period_start(ps0), .underrun(ur0), .duty_q(duty0)
  );

  pwm9_stage #(.PRESCALE(4)) u1 (
    .clk(clk), .reset(reset), .enable(enable1), .in_if(if1.slave),
    .pwm_out(pwm1), .period_start(ps1), .underrun(ur1), .duty_q(duty1)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_duty(input int code, input int frac);
`ifdef FRACTION_EN
    return code * 16 + frac;
`else
    return code * 16 + 0 * frac;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for u0: transfers push their expected duty, boundaries pop it.
  int sb_q[$];
  int model_duty = 0;
  int per_duty   = 0;
  int cyc        = 0;
  int highs      = 0;
  bit per_valid  = 1'b0;
  bit prev_reset = 1'b1;
  bit prev_xfer  = 1'b0;
  int prev_data  = 0;

  always @(negedge clk) begin
    if (prev_reset) begin
      sb_q.delete();
      model_duty = 0;
      per_valid  = 1'b0;
    end else begin
      if (ps0) begin
        if (per_valid) begin
          check("period_len", cyc, PER0);
          check("period_high", highs, per_duty);
        end
        if (sb_q.size() == 0) begin
          check("sb_underrun", int'(ur0), 1);
        end else begin
          check("sb_underrun", int'(ur0), 0);
          model_duty = sb_q.pop_front();
        end
        check("sb_duty", int'(duty0), model_duty);
        per_valid = 1'b1;
        per_duty  = model_duty;
        cyc       = 1;
        highs     = int'(pwm0);
      end else if (per_valid) begin
        cyc++;
        highs += int'(pwm0);
      end
      if (prev_xfer) sb_q.push_back(prev_data);
    end
    if (reset || !enable0) per_valid = 1'b0;
    prev_reset = reset;
    prev_xfer  = if0.in_valid && if0.in_ready && !reset;
    prev_data  = exp_duty(int'(if0.in_code), int'(if0.in_frac));
  end

  task automatic send0(input int code, input int frac);
    int n;
    n = 0;
    if0.in_code  = code[4:0];
    if0.in_frac  = frac[3:0];
    if0.in_valid = 1'b1;
    while (!if0.in_ready && n < 2000) begin
      step();
      n++;
    end
    if (n >= 2000) check("send_timeout", 0, 1);
    step();
    if0.in_valid = 1'b0;
  endtask

  task automatic wait_ps0(input bit need_load, input string tag);
    int n;
    n = 0;
    step();
    while (!(ps0 && (!need_load || !ur0)) && n < 1200) begin
      step();
      n++;
    end
    if (n >= 1200) check(tag, 0, 1);
  endtask

  typedef struct {
    int code;
    int frac;
    int duty_on;
    int duty_off;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int exp;
    int c1;
    int h1;

    vecs[0] = '{5, 3, 83, 80};
    vecs[1] = '{0, 0, 0, 0};
    vecs[2] = '{31, 15, 511, 496};
    vecs[3] = '{20, 7, 327, 320};
    vecs[4] = '{16, 8, 264, 256};
    vecs[5] = '{7, 12, 124, 112};

    reset = 1'b1;
    enable0 = 1'b1;
    enable1 = 1'b0;
    if0.in_valid = 1'b0; if0.in_code = 5'd0; if0.in_frac = 4'd0;
    if1.in_valid = 1'b0; if1.in_code = 5'd0; if1.in_frac = 4'd0;
    repeat (3) step();
    check("rst_in_ready", int'(if0.in_ready), 1);
    check("rst_pwm", int'(pwm0), 0);
    check("rst_duty", int'(duty0), 0);
    check("rst_ps", int'(ps0), 0);
    check("rst_underrun", int'(ur0), 0);
    reset = 1'b0;

    // Table: each sample loads at the next boundary, then one full period is measured.
    for (int i = 0; i < 6; i++) begin
`ifdef FRACTION_EN
      exp = vecs[i].duty_on;
`else
      exp = vecs[i].duty_off;
`endif
      send0(vecs[i].code, vecs[i].frac);
      wait_ps0(1'b1, "load_timeout");
      check($sformatf("vec%0d_duty", i), int'(duty0), exp);
      wait_ps0(1'b0, "period_timeout");
    end

    // Handshake: one sample accepted mid-period, a second held until the boundary frees the buffer.
    repeat (100) step();
    if0.in_code = 5'd10; if0.in_frac = 4'd0; if0.in_valid = 1'b1;
    step();
    if0.in_code = 5'd20;
    check("ready_drop", int'(if0.in_ready), 0);
    n = 0;
    while (!if0.in_ready && n < 1200) begin
      step();
      n++;
    end
    check("hold_accept_at_ps", int'(ps0), 1);
    check("hold_duty_first", int'(duty0), 160);
    step();
    if0.in_valid = 1'b0;
    check("ready_after_accept", int'(if0.in_ready), 0);
    wait_ps0(1'b1, "hold_load_timeout");
    check("hold_duty_second", int'(duty0), 320);

    // Starvation: two boundaries with nothing pending.
    for (int k = 0; k < 2; k++) begin
      wait_ps0(1'b0, "starve_timeout");
      check($sformatf("starve%0d_underrun", k), int'(ur0), 1);
      check($sformatf("starve%0d_duty", k), int'(duty0), 320);
    end

    // Disable mid-period with a sample pending, then re-enable.
    send0(16, 8);
    repeat (50) step();
    enable0 = 1'b0;
    step();
    check("disable_pwm", int'(pwm0), 0);
    repeat (20) step();
    check("idle_ps", int'(ps0), 0);
    check("idle_pwm", int'(pwm0), 0);
    check("idle_duty_kept", int'(duty0), 320);
    enable0 = 1'b1;
    step();
    step();
    check("reenable_ps", int'(ps0), 1);
    check("reenable_underrun", int'(ur0), 0);
    check("reenable_duty", int'(duty0), exp_duty(16, 8));

    // Reset mid-period discards the pending sample.
    send0(31, 15);
    repeat (30) step();
    reset = 1'b1;
    step();
    check("midrst_in_ready", int'(if0.in_ready), 1);
    check("midrst_duty", int'(duty0), 0);
    check("midrst_pwm", int'(pwm0), 0);
    check("midrst_ps", int'(ps0), 0);
    check("midrst_underrun", int'(ur0), 0);
    step();
    reset = 1'b0;
    wait_ps0(1'b0, "postrst_timeout");
    check("postrst_underrun", int'(ur0), 1);
    check("postrst_duty", int'(duty0), 0);

    // PRESCALE=4 instance.
    enable0 = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    if1.in_code = 5'd2; if1.in_frac = 4'd9; if1.in_valid = 1'b1;
    step();
    if1.in_valid = 1'b0;
    check("p4_ready_drop", int'(if1.in_ready), 0);
    enable1 = 1'b1;
    n = 0;
    while (!ps1 && n < 50) begin
      step();
      n++;
    end
    check("p4_first_ps", int'(ps1), 1);
    check("p4_first_underrun", int'(ur1), 0);
`ifdef FRACTION_EN
    check("p4_duty", int'(duty1), 41);
`else
    check("p4_duty", int'(duty1), 32);
`endif
    c1 = 0;
    h1 = 0;
    do begin
      h1 += int'(pwm1);
      c1++;
      step();
    end while (!ps1 && c1 < 3000);
    check("p4_period", c1, 2048);
`ifdef FRACTION_EN
    check("p4_high", h1, 164);
`else
    check("p4_high", h1, 128);
`endif
    check("p4_second_underrun", int'(ur1), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pwm9_stage.md
# pwm9_stage

Downstream output stage for the 5-bit up/down counter. Accepts the counter's 5-bit code plus the 4-bit fraction through a one-deep valid/ready buffer. Combines them into a 9-bit duty word and drives a single-bit PWM output with a 512-tick period. New duty values take effect only at period boundaries, so the output never glitches mid-period.

## Interface
- PRESCALE, 1: clk cycles per PWM tick; legal range 1..256
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- enable  input  1  high = run PWM; low = idle, output held low
- in_valid  input  1  in_code/in_frac valid this cycle
- in_ready  output  1  pending buffer empty; transfer on in_valid && in_ready
- in_code  input  5  integer part of duty (counter main_out)
- in_frac  input  4  fractional part of duty
- pwm_out  output  1  registered PWM output
- period_start  output  1  one-cycle pulse at start of each PWM period
- underrun  output  1  one-cycle pulse: period started with no new sample pending
- duty_q  output  9  duty currently in effect

## Operation
- Reset: state IDLE, phase=0, prescaler=0, pending empty, duty_q=0, in_ready=1, pwm_out=0, period_start=0, underrun=0.
- Pending buffer, one entry:
  - A transfer (in_valid && in_ready) stores the 9-bit word and marks the buffer full.
  - in_ready = !full; it is a registered signal.
  - With the buffer full, further in_valid is ignored; the source holds its data.
- Duty word with FRACTION_EN defined: {in_code, in_frac}.
- States:
  - IDLE: phase=0, prescaler=0, pwm_out=0, no pulses. The pending buffer keeps accepting and holding data. enable=1 moves to RUN.
  - RUN: the prescaler counts 0..PRESCALE-1. On PRESCALE-1 it wraps, and phase increments mod 512. enable=0 returns to IDLE next cycle and clears phase and prescaler. duty_q is retained.
- Boundary: a cycle with phase=0 and prescaler=0 in RUN. This includes the first RUN cycle after IDLE.
  - Buffer full: duty_q <= pending and the buffer empties. in_ready returns to 1 the next cycle.
  - Buffer empty: duty_q is unchanged and underrun pulses.
  - period_start pulses at every boundary.
- A transfer is never accepted in the same cycle as the boundary that empties the buffer, because in_ready is still 0 in that cycle.
- pwm_out is registered to (phase < duty_q) in RUN and 0 in IDLE.
  - duty_q=0: output constantly low.
  - duty_q=511: high for 511 of 512 ticks.
- Reset mid-period: returns immediately to the reset state and discards the pending entry.

## Timing
- Period = 512*PRESCALE clk cycles.
- pwm_out lags the phase/duty compare by 1 clk.
- period_start and underrun are registered and align with the cycle in which pwm_out reflects phase 0.
- Input-to-effect latency: from the transfer to the next boundary, at most 512*PRESCALE cycles, plus 1 cycle to appear on pwm_out.
- Throughput: at most one sample per period.

## Configuration
- FRACTION_EN defined: duty = {in_code, in_frac}, giving 9-bit resolution.
- FRACTION_EN undefined:
  - duty = {in_code, 4'b0000} and in_frac is ignored.
  - Duty is coarse, in steps of 16 ticks; 31 gives 496/512.
  - All other behaviour is identical.

## Test plan
All scenarios use PRESCALE=1 and FRACTION_EN defined unless stated.
- Reset with enable=1: in_ready=1 and pwm_out=0. Then push code=5, frac=3. First boundary sets duty_q=83; pwm_out is high exactly 83 cycles per 512 and period_start is spaced 512 cycles apart.
- Handshake and hold:
  - Push code=10, frac=0 mid-period: in_ready drops to 0.
  - Hold in_valid with code=20: it is not accepted until 1 cycle after the boundary.
  - duty_q becomes 160 at the boundary.
- No new sample for two periods: underrun pulses at each boundary and duty_q holds its last value.
- Extremes: code=0, frac=0 gives pwm_out low for a full period. code=31, frac=15 gives high for 511 cycles and low for 1.
- enable dropped mid-period: pwm_out=0 the next cycle. On re-enable, period_start pulses on the first RUN cycle and a pending sample is loaded. Reset asserted mid-period clears everything to reset values.
- PRESCALE=4 with FRACTION_EN undefined: code=2, frac=9 gives duty_q=32, a period of 2048 cycles, and pwm_out high for 128 cycles.
